// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the space invaders asteroid logic.
// Holds the spawn FSM state enum, LFSR seed, tap mask and step helper.
package space_invaders_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        PICK,
        REQ,
        REL,
        OVER
    } spawn_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a group of asynchronous level signals.
// Ports: slowclk/reset_n clock and async active-low reset, d_in raw, d_sync synchronised.
module sync2 #(
    parameter int W = 1
) (
    input  logic         slowclk,
    input  logic         reset_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_sync
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign d_sync = sync_q;

endmodule

// File: rtl/asteroid_spawn_scheduler.sv
// Decides when an asteroid spawns, which slot it takes and its entry X.
// Ports: run/collision/slot_busy/spawn_ack in (async), spawn_* grant, level, spawn_count, game_over out.
module asteroid_spawn_scheduler
    import space_invaders_pkg::*;
#(
    parameter int ASTEROID_COUNT  = 10,
    parameter int SCREEN_CORDW    = 16,
    parameter int H_RES           = 640,
    parameter int SPRITE_W        = 32,
    parameter int BASE_INTERVAL   = 8,
    parameter int MIN_INTERVAL    = 2,
    parameter int LEVEL_UP_SPAWNS = 16
) (
    input  logic                      slowclk,
    input  logic                      reset_n,
    input  logic                      run,
    input  logic                      collision,
    input  logic [ASTEROID_COUNT-1:0] slot_busy,
    input  logic                      spawn_ack,
    output logic                      spawn_valid,
    output logic [ASTEROID_COUNT-1:0] spawn_slot,
    output logic [SCREEN_CORDW-1:0]   spawn_x,
    output logic [3:0]                level,
    output logic [15:0]               spawn_count,
    output logic                      game_over
);

    localparam int IDX_W  = $clog2(ASTEROID_COUNT);
    localparam int X_SPAN = H_RES - SPRITE_W;

    logic [2:0]                ctl_s;
    logic                      run_s;
    logic                      collision_s;
    logic                      spawn_ack_s;
    logic [ASTEROID_COUNT-1:0] busy_s;

    sync2 #(.W(3)) u_sync_ctl (
        .slowclk (slowclk),
        .reset_n (reset_n),
        .d_in    ({run, collision, spawn_ack}),
        .d_sync  (ctl_s)
    );

    sync2 #(.W(ASTEROID_COUNT)) u_sync_busy (
        .slowclk (slowclk),
        .reset_n (reset_n),
        .d_in    (slot_busy),
        .d_sync  (busy_s)
    );

    assign {run_s, collision_s, spawn_ack_s} = ctl_s;

    spawn_state_t              state_q, state_d;
    logic [15:0]               timer_q, timer_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]          slot_idx_q, slot_idx_d;
    logic [15:0]               lfsr_q, lfsr_d;
    logic                      spawn_valid_q, spawn_valid_d;
    logic [ASTEROID_COUNT-1:0] spawn_slot_q, spawn_slot_d;
    logic [SCREEN_CORDW-1:0]   spawn_x_q, spawn_x_d;
    logic [3:0]                level_q, level_d;
    logic [15:0]               spawn_count_q, spawn_count_d;
    logic                      game_over_q, game_over_d;

    logic [IDX_W:0]            pick;
    logic [15:0]               count_inc;
    logic [9:0]                x_raw;
    logic [9:0]                x_fold;

    function automatic logic [15:0] interval_for(input logic [3:0] lvl);
        int v;
        v = BASE_INTERVAL - int'(lvl);
        if (v < MIN_INTERVAL) v = MIN_INTERVAL;
        return 16'(v);
    endfunction

    // Returns {found, index}; scans downward so the last hit is the
    // nearest free slot after rr.
    function automatic logic [IDX_W:0] rr_search(
        input logic [IDX_W-1:0]          rr,
        input logic [ASTEROID_COUNT-1:0] busy
    );
        logic [IDX_W:0] r;
        int cand;
        r = '0;
        for (int i = ASTEROID_COUNT; i >= 1; i--) begin
            cand = (int'(rr) + i) % ASTEROID_COUNT;
            if (!busy[cand]) r = {1'b1, IDX_W'(cand)};
        end
        return r;
    endfunction

    // Fold the 10-bit random value into the visible span.
    assign x_raw  = lfsr_q[9:0];
    assign x_fold = (x_raw >= 10'(X_SPAN)) ? x_raw - 10'(X_SPAN) : x_raw;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        rr_ptr_d      = rr_ptr_q;
        slot_idx_d    = slot_idx_q;
        spawn_slot_d  = spawn_slot_q;
        spawn_x_d     = spawn_x_q;
        level_d       = level_q;
        spawn_count_d = spawn_count_q;
        game_over_d   = game_over_q;
        lfsr_d        = lfsr_next(lfsr_q);
        count_inc     = spawn_count_q + 16'd1;
        pick          = rr_search(rr_ptr_q, busy_s);

        case (state_q)
            IDLE: begin
                spawn_slot_d = '0;
                spawn_x_d    = '0;
                if (run_s) begin
                    level_d       = '0;
                    spawn_count_d = '0;
                    game_over_d   = 1'b0;
                    timer_d       = interval_for(4'd0);
                    state_d       = WAIT;
                end
            end
            OVER: begin
                if (!run_s) state_d = IDLE;
            end
            default: begin
                if (collision_s) begin
                    state_d     = OVER;
                    game_over_d = 1'b1;
                end else if (!run_s) begin
                    state_d = IDLE;
                end else begin
                    case (state_q)
                        WAIT: begin
                            if (timer_q == 16'd1) state_d = PICK;
                            else timer_d = timer_q - 16'd1;
                        end
                        PICK: begin
                            // Never launch a request while the previous
                            // acknowledge is still visible.
                            if (pick[IDX_W] && !spawn_ack_s) begin
                                slot_idx_d   = pick[IDX_W-1:0];
                                spawn_slot_d = {{(ASTEROID_COUNT-1){1'b0}}, 1'b1}
                                               << pick[IDX_W-1:0];
                                spawn_x_d    = SCREEN_CORDW'(x_fold);
                                state_d      = REQ;
                            end
                        end
                        REQ: begin
                            if (spawn_ack_s) begin
                                rr_ptr_d      = slot_idx_q;
                                spawn_count_d = count_inc;
                                if ((32'(count_inc) % LEVEL_UP_SPAWNS) == 0
                                    && level_q != 4'hF)
                                    level_d = level_q + 4'd1;
                                state_d = REL;
                            end
                        end
                        REL: begin
                            if (!spawn_ack_s) begin
                                timer_d = interval_for(level_q);
                                state_d = WAIT;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase

        spawn_valid_d = (state_d == REQ);
    end

    always_ff @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            rr_ptr_q      <= IDX_W'(ASTEROID_COUNT - 1);
            slot_idx_q    <= '0;
            lfsr_q        <= LFSR_SEED;
            spawn_valid_q <= 1'b0;
            spawn_slot_q  <= '0;
            spawn_x_q     <= '0;
            level_q       <= '0;
            spawn_count_q <= '0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rr_ptr_q      <= rr_ptr_d;
            slot_idx_q    <= slot_idx_d;
            lfsr_q        <= lfsr_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_slot_q  <= spawn_slot_d;
            spawn_x_q     <= spawn_x_d;
            level_q       <= level_d;
            spawn_count_q <= spawn_count_d;
            game_over_q   <= game_over_d;
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_slot  = spawn_slot_q;
    assign spawn_x     = spawn_x_q;
    assign level       = level_q;
    assign spawn_count = spawn_count_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_asteroid_spawn_scheduler.sv
// Directed self-checking bench for asteroid_spawn_scheduler.
// Drives run/collision/slot_busy/ack and checks grants, timing and levels.
module tb_asteroid_spawn_scheduler;

    logic        slowclk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        collision;
    logic [9:0]  slot_busy;
    logic        spawn_ack;
    logic        spawn_valid;
    logic [9:0]  spawn_slot;
    logic [15:0] spawn_x;
    logic [3:0]  level;
    logic [15:0] spawn_count;
    logic        game_over;

    int checks;
    int errors;
    int done;
    int rr_m;
    int vcnt;
    int cnt;
    int idx;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    asteroid_spawn_scheduler dut (
        .slowclk     (slowclk),
        .reset_n     (reset_n),
        .run         (run),
        .collision   (collision),
        .slot_busy   (slot_busy),
        .spawn_ack   (spawn_ack),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_x     (spawn_x),
        .level       (level),
        .spawn_count (spawn_count),
        .game_over   (game_over)
    );

    always #5 slowclk = ~slowclk;

    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Reference LFSR; m_prev holds the value before the latest edge.
    always @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= m_step(m_lfsr);
        end
    end

    function automatic int fold(input int raw);
        return (raw >= 608) ? raw - 608 : raw;
    endfunction

    function automatic int exp_level(input int n);
        return (n / 16 > 15) ? 15 : n / 16;
    endfunction

    // ack-drop to valid: 2 sync + 1 REL exit + interval + 1 PICK
    function automatic int exp_wait(input int n);
        int iv;
        iv = 8 - exp_level(n);
        if (iv < 2) iv = 2;
        return 4 + iv;
    endfunction

    function automatic logic [9:0] onehot(input int i);
        logic [9:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_spawn(input int want_wait, input int want_x,
                            input logic [9:0] want_slot, input string tag);
        int n;
        int ex;
        n = 0;
        while (n < 200 && !spawn_valid) begin
            @(negedge slowclk);
            n++;
        end
        chk({tag, "_valid"}, 32'(spawn_valid), 32'd1);
        if (want_wait >= 0) chk({tag, "_wait"}, n, want_wait);
        chk({tag, "_slot"}, 32'(spawn_slot), 32'(want_slot));
        ex = (want_x < 0) ? fold(int'(m_prev[9:0])) : want_x;
        chk({tag, "_x"}, 32'(spawn_x), ex);
        repeat (2) @(negedge slowclk);
        chk({tag, "_hold"}, 32'(spawn_valid), 32'd1);
        spawn_ack = 1'b1;
        n = 0;
        while (n < 20 && spawn_valid) begin
            @(negedge slowclk);
            n++;
        end
        chk({tag, "_drop"}, 32'(spawn_valid), 32'd0);
        chk({tag, "_relslot"}, 32'(spawn_slot), 32'(want_slot));
        done++;
        chk({tag, "_count"}, 32'(spawn_count), done);
        chk({tag, "_level"}, 32'(level), exp_level(done));
        spawn_ack = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        done      = 0;
        rr_m      = 9;
        run       = 1'b0;
        collision = 1'b0;
        slot_busy = '0;
        spawn_ack = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(negedge slowclk);
        chk("rst_valid", 32'(spawn_valid), 0);
        chk("rst_slot", 32'(spawn_slot), 0);
        chk("rst_x", 32'(spawn_x), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_count", 32'(spawn_count), 0);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        reset_n = 1'b1;
        @(negedge slowclk);

        run = 1'b1;
        do_spawn(exp_wait(done), -1, 10'b0000000001, "first");
        rr_m = 0;
        do_spawn(exp_wait(done), -1, 10'b0000000010, "second");
        rr_m = 1;
        for (int i = 2; i < 10; i++) begin
            do_spawn(exp_wait(done), -1, onehot(i), "fill");
            rr_m = i;
        end

        slot_busy = 10'h00F;
        do_spawn(exp_wait(done), -1, 10'b0000010000, "rr_skip");
        rr_m = 4;

        slot_busy = 10'h3FF;
        vcnt = 0;
        repeat (40) begin
            @(negedge slowclk);
            if (spawn_valid) vcnt++;
        end
        chk("all_busy_no_req", vcnt, 0);
        slot_busy = 10'h37F;
        do_spawn(-1, -1, 10'b0010000000, "slot7");
        rr_m = 7;
        slot_busy = '0;

        while (done < 256) begin
            idx = (rr_m + 1) % 10;
            do_spawn(exp_wait(done), -1, onehot(idx), "ramp");
            rr_m = idx;
            if (done == 16) chk("level_16", 32'(level), 1);
            if (done == 96) chk("level_96", 32'(level), 6);
            if (done == 240) chk("level_240", 32'(level), 15);
        end
        chk("level_sat", 32'(level), 15);
        chk("count_256", 32'(spawn_count), 256);

        cnt = 0;
        while (cnt < 200 && !spawn_valid) begin
            @(negedge slowclk);
            cnt++;
        end
        chk("coll_req", 32'(spawn_valid), 1);
        collision = 1'b1;
        repeat (2) @(negedge slowclk);
        chk("coll_valid_c2", 32'(spawn_valid), 1);
        chk("coll_over_c2", 32'(game_over), 0);
        @(negedge slowclk);
        chk("coll_valid_c3", 32'(spawn_valid), 0);
        chk("coll_over_c3", 32'(game_over), 1);
        collision = 1'b0;
        run = 1'b0;
        repeat (4) @(negedge slowclk);
        chk("over_idle_valid", 32'(spawn_valid), 0);
        run = 1'b1;
        repeat (3) @(negedge slowclk);
        chk("restart_over", 32'(game_over), 0);
        chk("restart_level", 32'(level), 0);
        chk("restart_count", 32'(spawn_count), 0);
        done = 0;

        cnt = 0;
        while (cnt < 200 && !spawn_valid) begin
            @(negedge slowclk);
            cnt++;
        end
        chk("mid_req", 32'(spawn_valid), 1);
        chk("mid_slot", 32'(spawn_slot), 32'(onehot((rr_m + 1) % 10)));
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(spawn_valid), 0);
        chk("arst_slot", 32'(spawn_slot), 0);
        chk("arst_x", 32'(spawn_x), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_count", 32'(spawn_count), 0);
        chk("arst_over", 32'(game_over), 0);
        chk("arst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        @(negedge slowclk);
        reset_n = 1'b1;
        rr_m = 9;
        done = 0;
        do_spawn(exp_wait(done), -1, 10'b0000000001, "post_rst");
        rr_m = 0;

        force dut.lfsr_q = 16'h03FF;
        do_spawn(exp_wait(done), 415, onehot(1), "xfold_1023");
        release dut.lfsr_q;
        force dut.lfsr_q = 16'h025F;
        do_spawn(exp_wait(done), 607, onehot(2), "xfold_607");
        release dut.lfsr_q;
        force dut.lfsr_q = 16'h0260;
        do_spawn(exp_wait(done), 0, onehot(3), "xfold_608");
        release dut.lfsr_q;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
